// File: rtl/poly_coef_loader.sv
// -----------------------------------------------------------------------------
// poly_coef_loader
//
// Feeds the multiplier's coefficient BRAM. After a start pulse it accepts
// exactly N_COEF signed coefficients over a valid/ready stream. Each one is
// mapped into [0,Q), and every COEFS of them are packed into one D_SIZE word.
// The words are written to consecutive BRAM addresses starting at 0. A single
// done pulse follows the final write.
//
// Handshake: a beat transfers on a rising clk edge where in_valid & in_ready
// are both 1. in_ready depends only on the FSM state (high in LOAD) and never
// on in_valid. The producer holds in_coef stable while in_valid is high.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      1-cycle pulse; starts a load, honoured only in IDLE
//   in_valid   in_coef is valid
//   in_ready   loader accepts a beat this cycle (state == LOAD)
//   in_coef    signed two's-complement coefficient
//   wr_en      BRAM write enable (1 cycle per completed word)
//   wr_addr    BRAM word address, holds its value when wr_en is 0
//   wr_din     packed word, lane k at [k*COEF_W +: COEF_W]; holds its value
//   busy       high in LOAD and FLUSH
//   done       1-cycle pulse in DONE
//   err        sticky: an out-of-range coefficient was seen in this load
//   dbg_state  current FSM state, for checkers
// -----------------------------------------------------------------------------
module poly_coef_loader #(
  parameter int COEF_W  = 13,
  parameter int COEFS   = 4,
  parameter int D_SIZE  = 52,
  parameter int Q_DEPTH = 8,
  parameter int N_COEF  = 761,
  parameter int Q       = 4591
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [COEF_W-1:0]   in_coef,
  output logic                wr_en,
  output logic [Q_DEPTH-1:0]  wr_addr,
  output logic [D_SIZE-1:0]   wr_din,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          dbg_state
);

  localparam int N_WORDS = (N_COEF + COEFS - 1) / COEFS;
  localparam int LANE_W  = (COEFS > 1) ? $clog2(COEFS) : 1;
  localparam int CNT_W   = $clog2(N_COEF + 1);

  // Signed constants at COEF_W+1 bits, the width the mapping works in.
  localparam logic signed [COEF_W:0] Q_S    = (COEF_W+1)'(Q);
  localparam logic signed [COEF_W:0] HALF_S = (COEF_W+1)'((Q - 1) / 2);

  if (N_WORDS > (1 << Q_DEPTH)) begin : g_depth_check
    $error("poly_coef_loader: ceil(N_COEF/COEFS) exceeds 2**Q_DEPTH");
  end
  if (D_SIZE != COEF_W * COEFS) begin : g_width_check
    $error("poly_coef_loader: D_SIZE must equal COEF_W*COEFS");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LANE_W-1:0]        lane_cnt;
  logic [Q_DEPTH-1:0]       word_cnt;
  logic [CNT_W-1:0]         coef_cnt;
  logic [D_SIZE-1:0]        lane_buf;

  logic                     accept;
  logic                     last_beat;
  logic                     lane_full;
  logic signed [COEF_W:0]   coef_s;
  logic                     out_of_range;
  logic [COEF_W-1:0]        lane_val;
  logic [D_SIZE-1:0]        packed_nxt;

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state == S_LOAD) || (state == S_FLUSH);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  assign accept    = in_valid & in_ready;
  assign last_beat = (coef_cnt == CNT_W'(N_COEF - 1));
  assign lane_full = (lane_cnt == LANE_W'(COEFS - 1));

  // Map the incoming coefficient into [0,Q). Out-of-range values store as 0.
  always_comb begin
    coef_s       = $signed({in_coef[COEF_W-1], in_coef});
    out_of_range = (coef_s > HALF_S) || (coef_s < -HALF_S);
    lane_val     = coef_s[COEF_W] ? COEF_W'(coef_s + Q_S) : in_coef;
    if (out_of_range) begin
      lane_val = '0;
    end
  end

  // Lane buffer with the current beat merged in. Lanes above the current
  // one are still zero because the buffer is cleared after every write.
  always_comb begin
    packed_nxt = lane_buf;
    for (int k = 0; k < COEFS; k++) begin
      if (lane_cnt == LANE_W'(k)) begin
        packed_nxt[k*COEF_W +: COEF_W] = lane_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (accept && last_beat) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath. A word is written in the cycle after the beat that completes
  // it. The final beat also completes a word, and that write lands in FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt <= '0;
      word_cnt <= '0;
      coef_cnt <= '0;
      lane_buf <= '0;
      err      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_din   <= '0;
    end else begin
      wr_en <= 1'b0;
      if (state == S_IDLE && start) begin
        lane_cnt <= '0;
        word_cnt <= '0;
        coef_cnt <= '0;
        lane_buf <= '0;
        err      <= 1'b0;
      end else if (accept) begin
        coef_cnt <= coef_cnt + CNT_W'(1);
        if (out_of_range) begin
          err <= 1'b1;
        end
        if (lane_full || last_beat) begin
          wr_en    <= 1'b1;
          wr_addr  <= word_cnt;
          wr_din   <= packed_nxt;
          word_cnt <= word_cnt + Q_DEPTH'(1);
          lane_cnt <= '0;
          lane_buf <= '0;
        end else begin
          lane_cnt <= lane_cnt + LANE_W'(1);
          lane_buf <= packed_nxt;
        end
      end
    end
  end

endmodule
